pipeline_tracker: RTL and testbench

Parametrised, in-order pipeline register chain for the RV32 core. It generalises the fixed IF/ID/EX/MEM/WB register set into a `STAGES`-deep chain carrying a payload, a destination tag and a write flag per stage. It adds four behaviours the fixed chain does not have: per-stage valid bits, a stall at any chosen stage with bubble insertion below it, a flush of any prefix of the pipe, and a youngest-first forwarding lookup for `NUM_SRC` source tags. Hazard/forwarding logic and the stage datapaths connect to it; it replaces hand-wired `*_Ex/*_Mem/*_Wb` shadow signals.

---
 rtl/pipeline_tracker_pkg.sv | 17 +
 rtl/pipeline_tracker_if.sv | 45 ++++
 rtl/pipeline_tracker_stage.sv | 42 ++++
 rtl/pipeline_tracker.sv | 130 +++++++++++++
 tb/tb_pipeline_tracker.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_tracker_pkg.sv
// Shared types and helpers for the in-order pipeline register chain.
package pipeline_pkg;

    localparam int unsigned TAG_ZERO = 0;

    typedef enum logic [1:0] {
        ADVANCE,
        HOLD,
        BUBBLE,
        KILL
    } stage_ctl_e;

    function automatic int unsigned sat_idx(input int unsigned idx, input int unsigned stages);
        return (idx >= stages) ? (stages - 1) : idx;
    endfunction

endpackage

// File: rtl/pipeline_tracker_if.sv
// Handshake, control, forwarding and output bundle of pipeline_tracker.
interface pipeline_tracker_if #(
    parameter int unsigned STAGES    = 4,
    parameter int unsigned PAYLOAD_W = 32,
    parameter int unsigned TAG_W     = 5,
    parameter int unsigned NUM_SRC   = 2
);
    localparam int unsigned SIDX_W = $clog2(STAGES);
    localparam int unsigned CNT_W  = $clog2(STAGES + 1);

    logic                          in_valid;
    logic [PAYLOAD_W-1:0]          in_payload;
    logic [TAG_W-1:0]              in_tag;
    logic                          in_wr;
    logic                          in_ready;
    logic                          stall_en;
    logic [SIDX_W-1:0]             stall_stage;
    logic                          flush_en;
    logic [SIDX_W-1:0]             flush_upto;
    logic [NUM_SRC*TAG_W-1:0]      src_tag;
    logic [NUM_SRC-1:0]            fwd_hit;
    logic [NUM_SRC*SIDX_W-1:0]     fwd_sel;
    logic [NUM_SRC*PAYLOAD_W-1:0]  fwd_data;
    logic                          out_valid;
    logic [PAYLOAD_W-1:0]          out_payload;
    logic [TAG_W-1:0]              out_tag;
    logic                          out_wr;
    logic                          out_fire;
    logic [CNT_W-1:0]              occupancy;

    modport master (
        output in_valid, in_payload, in_tag, in_wr,
        output stall_en, stall_stage, flush_en, flush_upto, src_tag,
        input  in_ready, fwd_hit, fwd_sel, fwd_data,
        input  out_valid, out_payload, out_tag, out_wr, out_fire, occupancy
    );

    modport slave (
        input  in_valid, in_payload, in_tag, in_wr,
        input  stall_en, stall_stage, flush_en, flush_upto, src_tag,
        output in_ready, fwd_hit, fwd_sel, fwd_data,
        output out_valid, out_payload, out_tag, out_wr, out_fire, occupancy
    );

endinterface

// File: rtl/pipeline_tracker_stage.sv
// One pipeline stage register driven by a decoded per-stage control.
module pipe_stage_reg
    import pipeline_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 32,
    parameter int unsigned TAG_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  stage_ctl_e           ctl,
    input  logic                 nxt_valid,
    input  logic                 nxt_wr,
    input  logic [TAG_W-1:0]     nxt_tag,
    input  logic [PAYLOAD_W-1:0] nxt_payload,
    output logic                 valid,
    output logic                 wr,
    output logic [TAG_W-1:0]     tag,
    output logic [PAYLOAD_W-1:0] payload
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid   <= 1'b0;
            wr      <= 1'b0;
            tag     <= '0;
            payload <= '0;
        end else begin
            case (ctl)
                ADVANCE: begin
                    valid   <= nxt_valid;
                    wr      <= nxt_wr;
                    tag     <= nxt_tag;
                    payload <= nxt_payload;
                end
                HOLD: ;
                // bubbles and kills drop only the valid bit; stale fields stay put
                default: valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_tracker.sv
// STAGES-deep in-order register chain with stall/bubble, prefix flush and youngest-first forwarding.
module pipeline_tracker
    import pipeline_pkg::*;
#(
    parameter int unsigned STAGES    = 4,
    parameter int unsigned PAYLOAD_W = 32,
    parameter int unsigned TAG_W     = 5,
    parameter int unsigned NUM_SRC   = 2
) (
    input  logic               clk,
    input  logic               reset,
    pipeline_tracker_if.slave  bus
);

    localparam int unsigned SIDX_W = $clog2(STAGES);
    localparam int unsigned CNT_W  = $clog2(STAGES + 1);

    logic                 valid_q   [STAGES];
    logic                 wr_q      [STAGES];
    logic [TAG_W-1:0]     tag_q     [STAGES];
    logic [PAYLOAD_W-1:0] payload_q [STAGES];

    logic                 nxt_valid   [STAGES];
    logic                 nxt_wr      [STAGES];
    logic [TAG_W-1:0]     nxt_tag     [STAGES];
    logic [PAYLOAD_W-1:0] nxt_payload [STAGES];

    stage_ctl_e           ctl [STAGES];

    logic                 in_ready_c;
    logic                 accept;
    int unsigned          stall_s;
    int unsigned          flush_f;

    assign in_ready_c = !bus.stall_en && !bus.flush_en;
    assign accept     = bus.in_valid && in_ready_c;

    always_comb begin
        stall_s = sat_idx(32'(bus.stall_stage), STAGES);
        flush_f = sat_idx(32'(bus.flush_upto), STAGES);
    end

    // flush wins over hold; the bubble at stall_s+1 is injected even under a flush
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            ctl[k] = ADVANCE;
            if (bus.flush_en && k <= flush_f)
                ctl[k] = KILL;
            else if (bus.stall_en && k <= stall_s)
                ctl[k] = HOLD;
            else if (bus.stall_en && k == stall_s + 1)
                ctl[k] = BUBBLE;
            else if (k == 0 && !accept)
                ctl[k] = BUBBLE;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign nxt_valid[k]   = accept;
            assign nxt_wr[k]      = bus.in_wr;
            assign nxt_tag[k]     = bus.in_tag;
            assign nxt_payload[k] = bus.in_payload;
        end else begin : g_body
            assign nxt_valid[k]   = valid_q[k-1];
            assign nxt_wr[k]      = wr_q[k-1];
            assign nxt_tag[k]     = tag_q[k-1];
            assign nxt_payload[k] = payload_q[k-1];
        end

        pipe_stage_reg #(
            .PAYLOAD_W (PAYLOAD_W),
            .TAG_W     (TAG_W)
        ) u_reg (
            .clk         (clk),
            .reset       (reset),
            .ctl         (ctl[k]),
            .nxt_valid   (nxt_valid[k]),
            .nxt_wr      (nxt_wr[k]),
            .nxt_tag     (nxt_tag[k]),
            .nxt_payload (nxt_payload[k]),
            .valid       (valid_q[k]),
            .wr          (wr_q[k]),
            .tag         (tag_q[k]),
            .payload     (payload_q[k])
        );
    end

    logic [NUM_SRC-1:0]           hit;
    logic [NUM_SRC*SIDX_W-1:0]    sel;
    logic [NUM_SRC*PAYLOAD_W-1:0] data;

    // ascending scan with a first-match latch gives youngest-stage priority
    always_comb begin
        hit  = '0;
        sel  = '0;
        data = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (!hit[i] && valid_q[k] && wr_q[k] &&
                    tag_q[k] != TAG_W'(TAG_ZERO) &&
                    tag_q[k] == bus.src_tag[i*TAG_W +: TAG_W]) begin
                    hit[i]                       = 1'b1;
                    sel[i*SIDX_W +: SIDX_W]      = SIDX_W'(k);
                    data[i*PAYLOAD_W +: PAYLOAD_W] = payload_q[k];
                end
            end
        end
    end

    logic [CNT_W-1:0] count;

    always_comb begin
        count = '0;
        for (int unsigned k = 0; k < STAGES; k++)
            count = count + CNT_W'(valid_q[k]);
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.fwd_hit     = hit;
    assign bus.fwd_sel     = sel;
    assign bus.fwd_data    = data;
    assign bus.out_valid   = valid_q[STAGES-1];
    assign bus.out_payload = payload_q[STAGES-1];
    assign bus.out_tag     = tag_q[STAGES-1];
    assign bus.out_wr      = wr_q[STAGES-1];
    assign bus.out_fire    = valid_q[STAGES-1] && !(bus.stall_en && stall_s == STAGES - 1);
    assign bus.occupancy   = count;

endmodule

// File: tb/tb_pipeline_tracker.sv
// Directed self-checking bench for pipeline_tracker with STAGES=4.
module tb_pipeline_tracker;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    pipeline_tracker_if #(
        .STAGES    (4),
        .PAYLOAD_W (32),
        .TAG_W     (5),
        .NUM_SRC   (2)
    ) bus ();

    pipeline_tracker #(
        .STAGES    (4),
        .PAYLOAD_W (32),
        .TAG_W     (5),
        .NUM_SRC   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid    = 1'b0;
        bus.in_payload  = '0;
        bus.in_tag      = '0;
        bus.in_wr       = 1'b0;
        bus.stall_en    = 1'b0;
        bus.stall_stage = '0;
        bus.flush_en    = 1'b0;
        bus.flush_upto  = '0;
        bus.src_tag     = '0;
    endtask

    task automatic push(input logic [4:0] tag, input logic [31:0] payload, input logic wr);
        bus.in_valid   = 1'b1;
        bus.in_tag     = tag;
        bus.in_payload = payload;
        bus.in_wr      = wr;
        tick();
        bus.in_valid   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        bus.src_tag = {5'd3, 5'd1};
        tick();
        tick();
        #1;
        n_checks++; if (bus.occupancy !== 3'd0) begin n_fails++; $display("FAIL reset_occ got %0d exp 0", bus.occupancy); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        n_checks++; if (bus.out_tag !== 5'd0 || bus.out_payload !== 32'd0 || bus.out_wr !== 1'b0) begin n_fails++; $display("FAIL reset_out_fields got tag %0d pl %h wr %b exp zeros", bus.out_tag, bus.out_payload, bus.out_wr); end
        n_checks++; if (bus.out_fire !== 1'b0) begin n_fails++; $display("FAIL reset_out_fire got %b exp 0", bus.out_fire); end
        n_checks++; if (bus.fwd_hit !== 2'b00 || bus.fwd_sel !== 4'd0 || bus.fwd_data !== 64'd0) begin n_fails++; $display("FAIL reset_fwd got hit %b sel %h data %h exp zeros", bus.fwd_hit, bus.fwd_sel, bus.fwd_data); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        bus.stall_en = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fails++; $display("FAIL ready_stall got %b exp 0", bus.in_ready); end
        bus.stall_en = 1'b0;
        bus.flush_en = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fails++; $display("FAIL ready_flush got %b exp 0", bus.in_ready); end
        drive_idle();
        reset = 1'b0;
    endtask

    task automatic test_streaming();
        for (int j = 0; j < 4; j++) begin
            push(5'(j + 1), 32'((j + 1) * 16), 1'b1);
            n_checks++; if (bus.occupancy !== 3'(j + 1)) begin n_fails++; $display("FAIL stream_occ[%0d] got %0d exp %0d", j, bus.occupancy, j + 1); end
            n_checks++; if (bus.out_valid !== (j == 3)) begin n_fails++; $display("FAIL stream_out_valid[%0d] got %b exp %b", j, bus.out_valid, j == 3); end
        end
        bus.src_tag = {5'd1, 5'd3};
        #1;
        n_checks++; if (bus.fwd_hit !== 2'b11 || bus.fwd_sel !== 4'b1101 || bus.fwd_data !== {32'h10, 32'h30}) begin n_fails++; $display("FAIL stream_fwd got hit %b sel %b data %h exp 11 1101 %h", bus.fwd_hit, bus.fwd_sel, bus.fwd_data, {32'h10, 32'h30}); end
        n_checks++; if (bus.out_fire !== 1'b1 || bus.out_tag !== 5'd1 || bus.out_payload !== 32'h10) begin n_fails++; $display("FAIL stream_exit1 got fire %b tag %0d pl %h exp 1 1 10", bus.out_fire, bus.out_tag, bus.out_payload); end
        bus.src_tag = '0;
        for (int m = 1; m < 4; m++) begin
            tick();
            n_checks++; if (bus.out_fire !== 1'b1 || bus.out_tag !== 5'(m + 1) || bus.out_payload !== 32'((m + 1) * 16)) begin n_fails++; $display("FAIL stream_exit[%0d] got fire %b tag %0d pl %h exp 1 %0d %h", m, bus.out_fire, bus.out_tag, bus.out_payload, m + 1, (m + 1) * 16); end
            n_checks++; if (bus.occupancy !== 3'(4 - m)) begin n_fails++; $display("FAIL stream_drain_occ[%0d] got %0d exp %0d", m, bus.occupancy, 4 - m); end
        end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_fire !== 1'b0 || bus.occupancy !== 3'd0) begin n_fails++; $display("FAIL stream_empty got valid %b fire %b occ %0d exp 0 0 0", bus.out_valid, bus.out_fire, bus.occupancy); end
    endtask

    task automatic test_stall();
        for (int j = 1; j <= 4; j++) push(5'(j), 32'h10 + 32'(j), 1'b1);
        bus.in_valid = 1'b1; bus.in_tag = 5'd5; bus.in_payload = 32'h15; bus.in_wr = 1'b1;
        bus.stall_en = 1'b1; bus.stall_stage = 2'd1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0 || bus.out_fire !== 1'b1) begin n_fails++; $display("FAIL stall1_comb got ready %b fire %b exp 0 1", bus.in_ready, bus.out_fire); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd2 || bus.occupancy !== 3'd3) begin n_fails++; $display("FAIL stall1_c1 got valid %b tag %0d occ %0d exp 1 2 3", bus.out_valid, bus.out_tag, bus.occupancy); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 3'd2) begin n_fails++; $display("FAIL stall1_c2 got valid %b occ %0d exp 0 2", bus.out_valid, bus.occupancy); end
        bus.stall_en = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fails++; $display("FAIL stall_release_ready got %b exp 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 3'd3) begin n_fails++; $display("FAIL stall_bubble2 got valid %b occ %0d exp 0 3", bus.out_valid, bus.occupancy); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd3 || bus.out_payload !== 32'h13) begin n_fails++; $display("FAIL stall_order3 got valid %b tag %0d pl %h exp 1 3 13", bus.out_valid, bus.out_tag, bus.out_payload); end
        bus.stall_en = 1'b1; bus.stall_stage = 2'd3;
        #1;
        n_checks++; if (bus.out_fire !== 1'b0 || bus.in_ready !== 1'b0) begin n_fails++; $display("FAIL stall_last_fire got fire %b ready %b exp 0 0", bus.out_fire, bus.in_ready); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd3 || bus.occupancy !== 3'd3) begin n_fails++; $display("FAIL stall_last_hold got valid %b tag %0d occ %0d exp 1 3 3", bus.out_valid, bus.out_tag, bus.occupancy); end
        bus.stall_en = 1'b0;
        #1;
        n_checks++; if (bus.out_fire !== 1'b1) begin n_fails++; $display("FAIL stall_last_release got fire %b exp 1", bus.out_fire); end
        tick();
        n_checks++; if (bus.out_tag !== 5'd4 || bus.out_payload !== 32'h14 || bus.out_valid !== 1'b1) begin n_fails++; $display("FAIL stall_order4 got valid %b tag %0d pl %h exp 1 4 14", bus.out_valid, bus.out_tag, bus.out_payload); end
        tick();
        n_checks++; if (bus.out_tag !== 5'd5 || bus.out_payload !== 32'h15 || bus.out_valid !== 1'b1) begin n_fails++; $display("FAIL stall_order5 got valid %b tag %0d pl %h exp 1 5 15", bus.out_valid, bus.out_tag, bus.out_payload); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 3'd0) begin n_fails++; $display("FAIL stall_empty got valid %b occ %0d exp 0 0", bus.out_valid, bus.occupancy); end
        drive_idle();
    endtask

    task automatic test_flush_stall();
        for (int j = 1; j <= 4; j++) push(5'(j), 32'h20 + 32'(j), 1'b1);
        bus.flush_en = 1'b1; bus.flush_upto = 2'd1;
        bus.stall_en = 1'b1; bus.stall_stage = 2'd2;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0 || bus.out_fire !== 1'b1) begin n_fails++; $display("FAIL fs_comb got ready %b fire %b exp 0 1", bus.in_ready, bus.out_fire); end
        tick();
        n_checks++; if (bus.occupancy !== 3'd1 || bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL fs_c1 got occ %0d valid %b exp 1 0", bus.occupancy, bus.out_valid); end
        drive_idle();
        tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd2 || bus.out_payload !== 32'h22 || bus.occupancy !== 3'd1) begin n_fails++; $display("FAIL fs_c2 got valid %b tag %0d pl %h occ %0d exp 1 2 22 1", bus.out_valid, bus.out_tag, bus.out_payload, bus.occupancy); end
        tick();
        n_checks++; if (bus.occupancy !== 3'd0) begin n_fails++; $display("FAIL fs_empty got occ %0d exp 0", bus.occupancy); end
    endtask

    task automatic test_forwarding();
        push(5'd5, 32'hBB, 1'b1);
        push(5'd0, 32'h77, 1'b1);
        push(5'd5, 32'hAA, 1'b1);
        push(5'd9, 32'h99, 1'b0);
        bus.src_tag = {5'd0, 5'd5};
        #1;
        n_checks++; if (bus.fwd_hit !== 2'b01 || bus.fwd_sel !== 4'b0001 || bus.fwd_data !== {32'h0, 32'hAA}) begin n_fails++; $display("FAIL fwd_youngest got hit %b sel %b data %h exp 01 0001 %h", bus.fwd_hit, bus.fwd_sel, bus.fwd_data, {32'h0, 32'hAA}); end
        bus.src_tag = {5'd5, 5'd9};
        #1;
        n_checks++; if (bus.fwd_hit !== 2'b10 || bus.fwd_sel !== 4'b0100 || bus.fwd_data !== {32'hAA, 32'h0}) begin n_fails++; $display("FAIL fwd_wr0 got hit %b sel %b data %h exp 10 0100 %h", bus.fwd_hit, bus.fwd_sel, bus.fwd_data, {32'hAA, 32'h0}); end
        bus.src_tag = {5'd5, 5'd5};
        bus.flush_en = 1'b1; bus.flush_upto = 2'd3;
        #1;
        n_checks++; if (bus.fwd_hit !== 2'b11 || bus.fwd_sel !== 4'b0101) begin n_fails++; $display("FAIL fwd_both got hit %b sel %b exp 11 0101", bus.fwd_hit, bus.fwd_sel); end
        tick();
        bus.flush_en = 1'b0;
        #1;
        n_checks++; if (bus.fwd_hit !== 2'b00 || bus.fwd_sel !== 4'd0 || bus.fwd_data !== 64'd0 || bus.occupancy !== 3'd0) begin n_fails++; $display("FAIL fwd_invalid got hit %b sel %b data %h occ %0d exp 00 0 0 0", bus.fwd_hit, bus.fwd_sel, bus.fwd_data, bus.occupancy); end
        drive_idle();
    endtask

    task automatic test_reset_midstream();
        push(5'd1, 32'h31, 1'b1);
        push(5'd2, 32'h32, 1'b1);
        reset = 1'b1;
        bus.stall_en = 1'b1; bus.stall_stage = 2'd3;
        bus.in_valid = 1'b1; bus.in_tag = 5'd3; bus.in_payload = 32'h33; bus.in_wr = 1'b1;
        tick();
        reset = 1'b0;
        drive_idle();
        bus.src_tag = {5'd2, 5'd1};
        #1;
        n_checks++; if (bus.occupancy !== 3'd0 || bus.out_valid !== 1'b0 || bus.fwd_hit !== 2'b00) begin n_fails++; $display("FAIL mid_reset got occ %0d valid %b hit %b exp 0 0 00", bus.occupancy, bus.out_valid, bus.fwd_hit); end
        push(5'd10, 32'hA0, 1'b1);
        bus.src_tag = {5'd0, 5'd10};
        n_checks++; if (bus.occupancy !== 3'd1 || bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL post_reset_c1 got occ %0d valid %b exp 1 0", bus.occupancy, bus.out_valid); end
        tick();
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL post_reset_c3 got valid %b exp 0", bus.out_valid); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd10 || bus.out_payload !== 32'hA0) begin n_fails++; $display("FAIL post_reset_exit got valid %b tag %0d pl %h exp 1 10 a0", bus.out_valid, bus.out_tag, bus.out_payload); end
        n_checks++; if (bus.fwd_hit !== 2'b01 || bus.fwd_sel !== 4'b0011 || bus.fwd_data !== {32'h0, 32'hA0}) begin n_fails++; $display("FAIL post_reset_fwd got hit %b sel %b data %h exp 01 0011 %h", bus.fwd_hit, bus.fwd_sel, bus.fwd_data, {32'h0, 32'hA0}); end
        drive_idle();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b1;
        drive_idle();
        test_reset();
        test_streaming();
        test_stall();
        test_flush_stall();
        test_forwarding();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
